tpu_job_launcher: RTL and testbench

//  Host-side initiator of the TPU inference controller. Assembles a 32x32 1-bit image from row writes.
//  On start, arms the controller: ena high, reset pulse, then waits for done with a timeout.

---
 rtl/tpu_pkg.sv | 20 ++
 rtl/image_row_buffer.sv | 50 +++++
 rtl/tpu_job_launcher.sv | 164 ++++++++++++++++
 tb/tb_tpu_job_launcher.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// ----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the TPU job launcher and its image row buffer:
// image geometry, the launcher FSM state encoding and the digit code that
// reports an aborted job.
// ----------------------------------------------------------------------------
package tpu_pkg;

    localparam int IMG_W = 32;
    localparam int IMG_H = 32;

    localparam logic [3:0] RESULT_TIMEOUT = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/image_row_buffer.sv
// ----------------------------------------------------------------------------
// image_row_buffer
// IMG_H x IMG_W array of 1-bit pixels assembled one row at a time and
// presented to the controller as one flat bus.
// Ports:
//   clk_i    clock, posedge
//   rst_i    async active-high reset, zeroes every row
//   wr_i     write data_i into row addr_i (ignored for rows >= IMG_H)
//   addr_i   row index
//   data_i   row pixels, bit c = column c
//   clear_i  zero every row; takes priority over wr_i
//   lock_i   freeze the buffer, wr_i and clear_i are ignored
//   image_o  flat image, row r at [r*IMG_W +: IMG_W]
// ----------------------------------------------------------------------------
module image_row_buffer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [IMG_W-1:0]         data_i,
    input  logic                     clear_i,
    input  logic                     lock_i,
    output logic [IMG_W*IMG_H-1:0]   image_o
);

    // One register per row. An address at or beyond IMG_H matches no row,
    // so such writes simply fall on the floor.
    for (genvar r = 0; r < IMG_H; r++) begin : gRow
        logic [IMG_W-1:0] row_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                row_q <= '0;
            end else if (!lock_i) begin
                if (clear_i) begin
                    row_q <= '0;
                end else if (wr_i && (addr_i == ADDR_W'(r))) begin
                    row_q <= data_i;
                end
            end
        end

        assign image_o[r*IMG_W +: IMG_W] = row_q;
    end

endmodule

// File: rtl/tpu_job_launcher.sv
// ----------------------------------------------------------------------------
// tpu_job_launcher
// Host-side initiator for the TPU inference controller. Collects a 1-bit
// image through row writes, then on start enables the controller, holds its
// synchronous reset low for RST_PULSE cycles, and waits for done (bounded by
// TIMEOUT_CYCLES). The digit and overflow flag are latched for display/UART.
// Ports:
//   clk, iRst                 clock and async active-high reset
//   row_wr/row_addr/row_data  image row write (IDLE only)
//   clear                     zero the image (IDLE only, beats row_wr)
//   start                     launch one job (ignored while busy)
//   busy                      job in progress (ARM or RUN)
//   result_valid/num/ovf      last result, held until the next accepted start
//   timeout                   last job was aborted
//   tpu_ena/tpu_rst_n         controller enable and sync active-low reset
//   tpu_image                 image bus to the controller
//   tpu_num/overflow/done     controller result inputs, sampled only in RUN
// ----------------------------------------------------------------------------
module tpu_job_launcher #(
    parameter int IMG_W          = tpu_pkg::IMG_W,
    parameter int IMG_H          = tpu_pkg::IMG_H,
    parameter int RST_PULSE      = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     iRst,
    input  logic                     row_wr,
    input  logic [4:0]               row_addr,
    input  logic [IMG_W-1:0]         row_data,
    input  logic                     clear,
    input  logic                     start,
    output logic                     busy,
    output logic                     result_valid,
    output logic [3:0]               result_num,
    output logic                     result_ovf,
    output logic                     timeout,
    output logic                     tpu_ena,
    output logic                     tpu_rst_n,
    output logic [IMG_W*IMG_H-1:0]   tpu_image,
    input  logic [3:0]               tpu_num,
    input  logic                     tpu_overflow,
    input  logic                     tpu_done
);

    import tpu_pkg::*;

    localparam int RUN_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PULSE_W = ($clog2(RST_PULSE + 1) < 2) ? 2 : $clog2(RST_PULSE + 1);

    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE - 1);

    state_t               state_q, state_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic                 resultValid_q, resultValid_d;
    logic [3:0]           resultNum_q, resultNum_d;
    logic                 resultOvf_q, resultOvf_d;
    logic                 timeout_q, timeout_d;

    logic                 idle;

    assign idle = (state_q == IDLE);

    // The image is only writable while idle, so the controller sees a frozen
    // buffer from the first ARM cycle until the job ends.
    image_row_buffer #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (5)
    ) uBuffer (
        .clk_i   (clk),
        .rst_i   (iRst),
        .wr_i    (row_wr),
        .addr_i  (row_addr),
        .data_i  (row_data),
        .clear_i (clear),
        .lock_i  (!idle),
        .image_o (tpu_image)
    );

    // Next-state logic for the job FSM, its two counters and the result
    // registers. In RUN the done check is gated by run_q != 0 so a controller
    // still coming out of reset (possibly driving x) is never believed, and
    // done is tested before the timeout so it wins on a tie.
    always_comb begin
        state_d       = state_q;
        pulse_d       = pulse_q;
        run_d         = run_q;
        resultValid_d = resultValid_q;
        resultNum_d   = resultNum_q;
        resultOvf_d   = resultOvf_q;
        timeout_d     = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = ARM;
                    pulse_d       = '0;
                    resultValid_d = 1'b0;
                    timeout_d     = 1'b0;
                end
            end
            ARM: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = RUN;
                    run_d   = '0;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            RUN: begin
                run_d = run_q + 1'b1;
                if ((run_q != '0) && tpu_done) begin
                    state_d       = IDLE;
                    resultNum_d   = tpu_num;
                    resultOvf_d   = tpu_overflow;
                    resultValid_d = 1'b1;
                    timeout_d     = 1'b0;
                end else if (run_q == RUN_LAST) begin
                    state_d       = IDLE;
                    resultNum_d   = RESULT_TIMEOUT;
                    resultOvf_d   = 1'b0;
                    resultValid_d = 1'b1;
                    timeout_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset leaves the launcher idle with no
    // result and the controller disabled.
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_q       <= IDLE;
            pulse_q       <= '0;
            run_q         <= '0;
            resultValid_q <= 1'b0;
            resultNum_q   <= 4'h0;
            resultOvf_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pulse_q       <= pulse_d;
            run_q         <= run_d;
            resultValid_q <= resultValid_d;
            resultNum_q   <= resultNum_d;
            resultOvf_q   <= resultOvf_d;
            timeout_q     <= timeout_d;
        end
    end

    assign busy         = !idle;
    assign tpu_ena      = !idle;
    assign tpu_rst_n    = (state_q != ARM);
    assign result_valid = resultValid_q;
    assign result_num   = resultNum_q;
    assign result_ovf   = resultOvf_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_tpu_job_launcher.sv
// ----------------------------------------------------------------------------
// tb_tpu_job_launcher
// Self-checking bench for tpu_job_launcher with a behavioural controller and
// an image/result reference model.
// ----------------------------------------------------------------------------
module tb_tpu_job_launcher;

    localparam int IMG_W     = 32;
    localparam int IMG_H     = 32;
    localparam int RST_PULSE = 2;
    localparam int TOUT      = 200;

    logic                   clk = 1'b0;
    logic                   iRst = 1'b1;
    logic                   row_wr = 1'b0;
    logic [4:0]             row_addr = 5'd0;
    logic [IMG_W-1:0]       row_data = '0;
    logic                   clear = 1'b0;
    logic                   start = 1'b0;
    logic                   busy;
    logic                   result_valid;
    logic [3:0]             result_num;
    logic                   result_ovf;
    logic                   timeout;
    logic                   tpu_ena;
    logic                   tpu_rst_n;
    logic [IMG_W*IMG_H-1:0] tpu_image;
    logic [3:0]             tpu_num;
    logic                   tpu_overflow;
    logic                   tpu_done;

    int checks = 0;
    int errors = 0;

    logic [IMG_W-1:0] expImg [IMG_H];

    int         ctlDoneAt = 1000000;
    logic [3:0] ctlNum = 4'h0;
    logic       ctlOvf = 1'b0;
    int         ctlCount = 0;

    always #5 clk = ~clk;

    tpu_job_launcher #(
        .IMG_W          (IMG_W),
        .IMG_H          (IMG_H),
        .RST_PULSE      (RST_PULSE),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk          (clk),
        .iRst         (iRst),
        .row_wr       (row_wr),
        .row_addr     (row_addr),
        .row_data     (row_data),
        .clear        (clear),
        .start        (start),
        .busy         (busy),
        .result_valid (result_valid),
        .result_num   (result_num),
        .result_ovf   (result_ovf),
        .timeout      (timeout),
        .tpu_ena      (tpu_ena),
        .tpu_rst_n    (tpu_rst_n),
        .tpu_image    (tpu_image),
        .tpu_num      (tpu_num),
        .tpu_overflow (tpu_overflow),
        .tpu_done     (tpu_done)
    );

    // Behavioural controller: counts enabled cycles since its reset and
    // raises done once ctlDoneAt cycles have elapsed.
    always @(posedge clk) begin
        if (!tpu_rst_n) ctlCount <= 0;
        else if (tpu_ena) ctlCount <= ctlCount + 1;
    end

    assign tpu_done     = tpu_ena && tpu_rst_n && (ctlCount >= ctlDoneAt);
    assign tpu_num      = tpu_done ? ctlNum : 4'h0;
    assign tpu_overflow = tpu_done ? ctlOvf : 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkImage(input string tag);
        for (int r = 0; r < IMG_H; r++) begin
            checkOutput(tag, tpu_image[r*IMG_W +: IMG_W], expImg[r]);
        end
    endtask

    // One idle-time buffer operation, applied on the next posedge.
    task automatic applyStimulus(input logic wr, input logic [4:0] addr,
                                 input logic [31:0] data, input logic clr);
        row_wr   = wr;
        row_addr = addr;
        row_data = data;
        clear    = clr;
        if (clr) begin
            for (int r = 0; r < IMG_H; r++) expImg[r] = '0;
        end else if (wr && (int'(addr) < IMG_H)) begin
            expImg[addr] = data;
        end
        @(posedge clk);
        #1;
        row_wr = 1'b0;
        clear  = 1'b0;
        @(negedge clk);
    endtask

    task automatic startJob(input int doneAt, input logic [3:0] num, input logic ovf,
                            input logic wr, input logic [4:0] addr, input logic [31:0] data);
        ctlDoneAt = doneAt;
        ctlNum    = num;
        ctlOvf    = ovf;
        start     = 1'b1;
        row_wr    = wr;
        row_addr  = addr;
        row_data  = data;
        if (wr) expImg[addr] = data;
        @(posedge clk);
        #1;
        start  = 1'b0;
        row_wr = 1'b0;
    endtask

    task automatic waitJob(input int doneAt, input logic [3:0] num, input logic ovf,
                           input bit junk, input logic [4:0] watchRow);
        int busyCnt = 0;
        int rstLow  = 0;
        int eff;
        int expRun;
        bit expTo;
        eff = (doneAt < 1) ? 1 : doneAt;
        if (eff <= TOUT - 1) begin
            expTo  = 1'b0;
            expRun = eff + 1;
        end else begin
            expTo  = 1'b1;
            expRun = TOUT;
        end
        forever begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            busyCnt++;
            if (tpu_rst_n === 1'b0) rstLow++;
            if (busyCnt == 1) begin
                checkOutput("validClearedOnStart", result_valid, 0);
                checkOutput("timeoutClearedOnStart", timeout, 0);
            end
            if (busyCnt == 4) begin
                checkOutput("imgDuringJob", tpu_image[watchRow*IMG_W +: IMG_W], expImg[watchRow]);
            end
            if (junk && busyCnt == 10) begin
                row_wr   = 1'b1;
                row_addr = 5'd0;
                row_data = 32'hFFFF_FFFF;
                start    = 1'b1;
            end
            if (junk && busyCnt == 11) begin
                row_wr = 1'b0;
                start  = 1'b0;
            end
            if (busyCnt > TOUT + 50) break;
        end
        row_wr = 1'b0;
        start  = 1'b0;
        checkOutput("idleAfterJob", busy, 0);
        checkOutput("busyCycles", busyCnt, RST_PULSE + expRun);
        checkOutput("rstLowCycles", rstLow, RST_PULSE);
        checkOutput("resultValid", result_valid, 1);
        checkOutput("resultNum", result_num, expTo ? 32'hF : 32'(num));
        checkOutput("resultOvf", result_ovf, expTo ? 0 : 32'(ovf));
        checkOutput("timeoutFlag", timeout, 32'(expTo));
    endtask

    initial begin
        int doneAt;
        logic [3:0] num;
        logic ovf;
        logic [4:0] a;

        for (int r = 0; r < IMG_H; r++) expImg[r] = '0;

        // Reset values while reset is held, sampled mid-cycle.
        #3;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstValid", result_valid, 0);
        checkOutput("rstNum", result_num, 0);
        checkOutput("rstOvf", result_ovf, 0);
        checkOutput("rstTimeout", timeout, 0);
        checkOutput("rstEna", tpu_ena, 0);
        checkOutput("rstRstN", tpu_rst_n, 1);
        checkImage("rstImg");
        repeat (2) @(negedge clk);
        iRst = 1'b0;
        @(negedge clk);

        // Normal job on a full image.
        $display("[TB] normal job");
        for (int r = 0; r < IMG_H; r++) applyStimulus(1'b1, 5'(r), 32'hA5A5_0000 | 32'(r), 1'b0);
        startJob(100, 4'd7, 1'b0, 1'b0, 5'd0, 32'h0);
        waitJob(100, 4'd7, 1'b0, 1'b0, 5'd5);
        checkOutput("row5", tpu_image[5*IMG_W +: IMG_W], 32'hA5A5_0005);
        checkImage("imgAfterJob");

        // Timeout with a silent controller.
        $display("[TB] timeout job");
        startJob(1000000, 4'd2, 1'b1, 1'b0, 5'd0, 32'h0);
        waitJob(1000000, 4'd2, 1'b1, 1'b0, 5'd1);

        // Writes and a second start while running are ignored.
        $display("[TB] start/write during run");
        startJob(100, 4'd9, 1'b1, 1'b0, 5'd0, 32'h0);
        waitJob(100, 4'd9, 1'b1, 1'b1, 5'd0);
        repeat (3) @(negedge clk);
        checkOutput("noQueuedStart", busy, 0);
        checkImage("imgAfterRunWrite");

        // clear beats a same-edge row write.
        $display("[TB] clear vs write");
        applyStimulus(1'b1, 5'd3, 32'h1, 1'b1);
        checkOutput("row3AfterClear", tpu_image[3*IMG_W +: IMG_W], 32'h0);
        checkImage("imgAfterClear");

        // Randomised jobs with boundary done timings.
        $display("[TB] random jobs");
        for (int j = 0; j < 7; j++) begin
            repeat (4) applyStimulus(1'b1, 5'($urandom_range(0, 31)), $urandom,
                                     ($urandom_range(0, 9) == 0));
            case (j)
                0: doneAt = 0;
                1: doneAt = 1;
                2: doneAt = TOUT - 1;
                3: doneAt = TOUT;
                default: doneAt = $urandom_range(2, 150);
            endcase
            num = 4'($urandom_range(0, 15));
            ovf = 1'($urandom_range(0, 1));
            a   = 5'($urandom_range(0, 31));
            startJob(doneAt, num, ovf, 1'b1, a, $urandom);
            waitJob(doneAt, num, ovf, 1'b0, a);
            checkImage("imgRandom");
        end

        // Reset in the middle of a run, then a clean job.
        $display("[TB] reset during run");
        startJob(100, 4'd5, 1'b0, 1'b0, 5'd0, 32'h0);
        repeat (20) @(negedge clk);
        #2;
        iRst = 1'b1;
        #1;
        for (int r = 0; r < IMG_H; r++) expImg[r] = '0;
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstEna", tpu_ena, 0);
        checkOutput("midRstRstN", tpu_rst_n, 1);
        checkOutput("midRstValid", result_valid, 0);
        checkOutput("midRstNum", result_num, 0);
        checkImage("midRstImg");
        @(negedge clk);
        iRst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 5'd7, 32'h0000_0080, 1'b0);
        startJob(40, 4'd3, 1'b0, 1'b0, 5'd0, 32'h0);
        waitJob(40, 4'd3, 1'b0, 1'b0, 5'd7);
        checkImage("imgAfterRecovery");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
